// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts the 1s over a window of 2^BITWIDTH accepted bits and
// holds the decoded value under valid/ready. Define SC_DECODER_BIPOLAR_EN for bipolar output encoding.
module sc_bitstream_decoder #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iBit,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oVal,
    output logic                oValid,
    output logic                oSat,
    output logic                oBusy
);

    localparam int W = BITWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         nextState_s;
    logic [W-1:0]   cntBits_r;
    logic [W:0]     cntOnes_r;
    logic           acceptBit_s;
    logic           windowDone_s;
    logic           handshake_s;
    logic [W:0]     onesNext_s;
    logic [W:0]     result_s;

    // Maps a ones count (0..N) to {sat, value}; only a full-ones window saturates.
    function automatic logic [W:0] decodeOnes(input logic [W:0] ones);
        logic [W-1:0] val;
        logic         sat;
`ifdef SC_DECODER_BIPOLAR_EN
        if (ones[W]) begin
            val = {1'b0, {(W-1){1'b1}}};
            sat = 1'b1;
        end else begin
            val = ones[W-1:0] - {1'b1, {(W-1){1'b0}}};
            sat = 1'b0;
        end
`else
        if (ones[W]) begin
            val = {W{1'b1}};
            sat = 1'b1;
        end else begin
            val = ones[W-1:0];
            sat = 1'b0;
        end
`endif
        return {sat, val};
    endfunction

    // Next-state decode; iClr overrides any accept, completion or handshake in this cycle.
    always_comb begin
        nextState_s  = state_r;
        acceptBit_s  = 1'b0;
        windowDone_s = 1'b0;
        handshake_s  = 1'b0;
        onesNext_s   = cntOnes_r + {{W{1'b0}}, iBit};
        if (iClr) begin
            nextState_s = IDLE;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    acceptBit_s = iEn;
                    if (iEn && (cntBits_r == {W{1'b1}})) begin
                        windowDone_s = 1'b1;
                        nextState_s  = HOLD;
                    end else if (iEn) begin
                        nextState_s = ACCUM;
                    end else begin
                        nextState_s = state_r;
                    end
                end
                HOLD: begin
                    if (iReady) begin
                        handshake_s = 1'b1;
                        nextState_s = IDLE;
                    end else begin
                        nextState_s = HOLD;
                    end
                end
                default: begin
                    nextState_s = IDLE;
                end
            endcase
        end
        result_s = decodeOnes(onesNext_s);
    end

    // State, counters and registered outputs; oVal survives iClr but not iRst.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r   <= IDLE;
            cntBits_r <= {W{1'b0}};
            cntOnes_r <= {(W+1){1'b0}};
            oVal      <= {W{1'b0}};
            oValid    <= 1'b0;
            oSat      <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            state_r <= nextState_s;
            oBusy   <= (nextState_s == HOLD);
            if (iClr || handshake_s) begin
                cntBits_r <= {W{1'b0}};
                cntOnes_r <= {(W+1){1'b0}};
                oValid    <= 1'b0;
                oSat      <= 1'b0;
            end else if (windowDone_s) begin
                cntBits_r <= {W{1'b0}};
                cntOnes_r <= onesNext_s;
                oVal      <= result_s[W-1:0];
                oSat      <= result_s[W];
                oValid    <= 1'b1;
            end else if (acceptBit_s) begin
                cntBits_r <= cntBits_r + {{(W-1){1'b0}}, 1'b1};
                cntOnes_r <= onesNext_s;
            end else begin
                cntBits_r <= cntBits_r;
                cntOnes_r <= cntOnes_r;
            end
        end
    end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Self-checking bench for sc_bitstream_decoder (BITWIDTH=8); expected results are queued as
// each window is driven and popped when the decoded value appears.
module tb_sc_bitstream_decoder;

    localparam int N = 256;

    logic       iClk = 1'b0;
    logic       iRst, iEn, iClr, iBit, iReady;
    logic [7:0] oVal;
    logic       oValid, oSat, oBusy;

    int         vecCount = 0;
    int         missCount = 0;
    logic [8:0] expQ[$];

    always #5 iClk = ~iClk;

    sc_bitstream_decoder #(.BITWIDTH(8)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iBit(iBit), .iReady(iReady),
        .oVal(oVal), .oValid(oValid), .oSat(oSat), .oBusy(oBusy)
    );

    function automatic logic [8:0] expOf(input int ones);
        int         d;
        logic [7:0] v;
`ifdef SC_DECODER_BIPOLAR_EN
        if (ones >= N) return {1'b1, 8'h7F};
        d = ones - 128;
        v = d[7:0];
        return {1'b0, v};
`else
        if (ones >= N) return {1'b1, 8'hFF};
        d = ones;
        v = d[7:0];
        return {1'b0, v};
`endif
    endfunction

    // kind: 0 alternating 1/0, 1 all ones, 2 all zeros, 3 first k ones then zeros
    task automatic sendWindow(input int kind, input int k, input int gapMax, input logic holdEn,
                              output logic fv, output logic pv, output logic qv, output logic qb,
                              output logic [8:0] got);
        int   ones;
        logic b;
        ones = 0;
        fv = 1'b0;
        pv = 1'b0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: b = (i % 2 == 0);
                1: b = 1'b1;
                2: b = 1'b0;
                default: b = (i < k);
            endcase
            if (gapMax > 0) begin
                repeat ($urandom_range(gapMax, 0)) begin
                    @(negedge iClk);
                    iEn = 1'b0;
                    iBit = 1'($urandom_range(1, 0));
                end
            end
            @(negedge iClk);
            if (i == 0) fv = oValid;
            if (i == N - 1) pv = oValid;
            iEn = 1'b1;
            iBit = b;
            ones += b ? 1 : 0;
        end
        expQ.push_back(expOf(ones));
        @(negedge iClk);
        qv = oValid;
        qb = oBusy;
        got = {oSat, oVal};
        iEn = holdEn;
        iBit = holdEn;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iBit = 1'b0; iReady = 1'b1;
        repeat (3) @(negedge iClk);
        vecCount++;
        if ({oVal, oValid, oSat, oBusy} !== 11'd0) begin
            missCount++;
            $display("FAIL reset: got val=%h v=%b s=%b b=%b want all 0", oVal, oValid, oSat, oBusy);
        end
        iRst = 1'b0;
        @(negedge iClk);
    endtask

    task automatic test_patterns();
        logic fv, pv, qv, qb;
        logic [8:0] got, exp;
        for (int kind = 0; kind < 3; kind++) begin
            sendWindow(kind, 0, 0, 1'b0, fv, pv, qv, qb, got);
            exp = expQ.pop_front();
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("FAIL pattern%0d value: got sat/val=%h want %h", kind, got, exp);
            end
            vecCount++;
            if ({pv, qv, qb} !== 3'b011) begin
                missCount++;
                $display("FAIL pattern%0d timing: got pre/valid/busy=%b%b%b want 011", kind, pv, qv, qb);
            end
            @(negedge iClk);
            vecCount++;
            if ({oValid, oBusy} !== 2'b00) begin
                missCount++;
                $display("FAIL pattern%0d release: got valid/busy=%b%b want 00", kind, oValid, oBusy);
            end
        end
    endtask

    task automatic test_gaps();
        logic fv, pv, qv, qb;
        logic [8:0] got, exp;
        sendWindow(3, 64, 3, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL gaps value: got %h want %h", got, exp);
        end
        vecCount++;
        if ({pv, qv} !== 2'b01) begin
            missCount++;
            $display("FAIL gaps latency: got pre/post valid=%b%b want 01", pv, qv);
        end
        @(negedge iClk);
    endtask

    task automatic test_back_to_back();
        logic fv, pv, qv, qb;
        logic [8:0] got, exp;
        sendWindow(1, 0, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL b2b first: got %h want %h", got, exp);
        end
        sendWindow(3, 200, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp || fv !== 1'b0 || qv !== 1'b1) begin
            missCount++;
            $display("FAIL b2b second: got %h fv=%b qv=%b want %h fv=0 qv=1", got, fv, qv, exp);
        end
        @(negedge iClk);
    endtask

    task automatic test_backpressure();
        logic fv, pv, qv, qb;
        logic [8:0] got, exp;
        iReady = 1'b0;
        sendWindow(3, 64, 0, 1'b1, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL bp value: got %h want %h", got, exp);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge iClk);
            vecCount++;
            if ({oValid, oBusy} !== 2'b11 || {oSat, oVal} !== exp) begin
                missCount++;
                $display("FAIL bp hold%0d: got v/b=%b%b val=%h want 11 %h", j, oValid, oBusy, {oSat, oVal}, exp);
            end
            if (j == 4) iReady = 1'b1;
        end
        @(negedge iClk);
        iEn = 1'b0;
        vecCount++;
        if ({oValid, oBusy} !== 2'b00) begin
            missCount++;
            $display("FAIL bp release: got valid/busy=%b%b want 00", oValid, oBusy);
        end
        sendWindow(2, 0, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL bp next window: got %h want %h", got, exp);
        end
        @(negedge iClk);
    endtask

    task automatic test_clr();
        logic fv, pv, qv, qb;
        logic [8:0] got, exp;
        for (int i = 0; i < 100; i++) begin
            @(negedge iClk);
            iEn = 1'b1; iBit = 1'b1;
        end
        @(negedge iClk);
        iClr = 1'b1; iEn = 1'b1; iBit = 1'b1;
        @(negedge iClk);
        iClr = 1'b0; iEn = 1'b0;
        vecCount++;
        if ({oValid, oBusy} !== 2'b00) begin
            missCount++;
            $display("FAIL clr accum: got valid/busy=%b%b want 00", oValid, oBusy);
        end
        sendWindow(2, 0, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp || pv !== 1'b0) begin
            missCount++;
            $display("FAIL clr window: got %h pre=%b want %h pre=0", got, pv, exp);
        end
        @(negedge iClk);
        iReady = 1'b0;
        sendWindow(1, 0, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL clr hold value: got %h want %h", got, exp);
        end
        @(negedge iClk);
        iClr = 1'b1;
        @(negedge iClk);
        iClr = 1'b0;
        vecCount++;
        if ({oValid, oSat, oBusy} !== 3'b000) begin
            missCount++;
            $display("FAIL clr hold: got v/s/b=%b%b%b want 000", oValid, oSat, oBusy);
        end
        iReady = 1'b1;
        @(negedge iClk);
    endtask

    task automatic test_rst();
        logic fv, pv, qv, qb;
        logic [8:0] got, exp;
        for (int i = 0; i < 100; i++) begin
            @(negedge iClk);
            iEn = 1'b1; iBit = 1'b1;
        end
        @(negedge iClk);
        iRst = 1'b1; iEn = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        vecCount++;
        if ({oVal, oValid, oSat, oBusy} !== 11'd0) begin
            missCount++;
            $display("FAIL rst accum: got val=%h v/s/b=%b%b%b want 0", oVal, oValid, oSat, oBusy);
        end
        iReady = 1'b0;
        sendWindow(1, 0, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL rst pre-hold value: got %h want %h", got, exp);
        end
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        vecCount++;
        if ({oVal, oValid, oSat, oBusy} !== 11'd0) begin
            missCount++;
            $display("FAIL rst hold: got val=%h v/s/b=%b%b%b want 0", oVal, oValid, oSat, oBusy);
        end
        iReady = 1'b1;
        sendWindow(0, 0, 0, 1'b0, fv, pv, qv, qb, got);
        exp = expQ.pop_front();
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL rst after window: got %h want %h", got, exp);
        end
        @(negedge iClk);
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_gaps();
        test_back_to_back();
        test_backpressure();
        test_clr();
        test_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
